// File: rtl/addr_gen.sv
// Multi-channel address generator: WRAP / BOUNDED / ONESHOT stepping over [lo, hi].
// Define ADDR_GEN_DIR_EN to add a latched count-direction input (dir).
module addr_gen #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 en,
`ifdef ADDR_GEN_DIR_EN
  input  logic                 dir,
`endif
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     incr,
  input  logic [WIDTH-1:0]     lo,
  input  logic [WIDTH-1:0]     hi,
  input  logic [NCH*WIDTH-1:0] offset,
  output logic [NCH*WIDTH-1:0] addr,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] acc_q, acc_n;
  logic [WIDTH-1:0] incr_q, lo_q, hi_q;
  logic [1:0]       mode_q;
  logic             err_q, err_n;
  logic             load;

  logic             down;
  logic [WIDTH-1:0] load_val;

`ifdef ADDR_GEN_DIR_EN
  logic dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else if (load) begin
      dir_q <= dir;
    end
  end

  assign down     = dir_q;
  assign load_val = dir ? hi : lo;
`else
  assign down     = 1'b0;
  assign load_val = lo;
`endif

  logic [WIDTH:0]   sum, dif;
  logic             over, under, oob;
  logic [WIDTH-1:0] step, reload, clamp;

  // Sums carry an extra bit so crossing 2^WIDTH or zero counts as out of window
  assign sum    = {1'b0, acc_q} + {1'b0, incr_q};
  assign dif    = {1'b0, acc_q} - {1'b0, incr_q};
  assign over   = sum > {1'b0, hi_q};
  assign under  = dif[WIDTH] || (dif[WIDTH-1:0] < lo_q);
  assign oob    = down ? under : over;
  assign step   = down ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
  assign reload = down ? hi_q : lo_q;
  assign clamp  = down ? lo_q : hi_q;

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    err_n   = err_q;
    load    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (en && incr_q != '0) begin
          unique case (mode_q)
            2'b01: acc_n = oob ? reload : step;
            2'b10: begin
              if (oob) begin
                acc_n   = clamp;
                state_n = DONE;
              end else begin
                acc_n = step;
              end
            end
            default: acc_n = step;
          endcase
        end
      end
      default: begin
        if (start) begin
          if (lo <= hi) begin
            load    = 1'b1;
            acc_n   = load_val;
            err_n   = 1'b0;
            state_n = RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
      mode_q  <= 2'b00;
      incr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      err_q   <= err_n;
      if (load) begin
        mode_q <= mode;
        incr_q <= incr;
        lo_q   <= lo;
        hi_q   <= hi;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign addr[k*WIDTH +: WIDTH] = acc_q + offset[k*WIDTH +: WIDTH];
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign cfg_err = err_q;

endmodule

// File: tb/tb_addr_gen.sv
// Directed vector bench for addr_gen (WIDTH=8, NCH=2).
// Table rows: inputs for one clock, then expected outputs after the edge.
module tb_addr_gen;

  logic        clk;
  logic        rst;
  logic        start, stop, en;
  logic [1:0]  mode;
  logic [7:0]  incr, lo, hi;
  logic [15:0] offset;
  logic [15:0] addr;
  logic        busy, done, cfg_err;
`ifdef ADDR_GEN_DIR_EN
  logic        dir;
`endif

  int total = 0;
  int bad   = 0;

  addr_gen #(.WIDTH(8), .NCH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .en      (en),
`ifdef ADDR_GEN_DIR_EN
    .dir     (dir),
`endif
    .mode    (mode),
    .incr    (incr),
    .lo      (lo),
    .hi      (hi),
    .offset  (offset),
    .addr    (addr),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, en;
    logic [1:0] mode;
    logic [7:0] incr, lo, hi, off1;
    logic [7:0] e_acc, e_a1;
    logic       e_busy, e_done, e_err;
  } vec_t;

  localparam int NV = 39;
  vec_t tv [NV];

  function automatic vec_t v(
    logic st, logic sp, logic en_i, logic [1:0] md,
    logic [7:0] inc, logic [7:0] l, logic [7:0] h, logic [7:0] o1,
    logic [7:0] ea, logic [7:0] ea1, logic eb, logic ed, logic ee);
    vec_t r;
    r.st = st; r.sp = sp; r.en = en_i; r.mode = md;
    r.incr = inc; r.lo = l; r.hi = h; r.off1 = o1;
    r.e_acc = ea; r.e_a1 = ea1;
    r.e_busy = eb; r.e_done = ed; r.e_err = ee;
    return r;
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // WRAP from 0 by 0x60
    tv[0]  = v(1,0,0,0,8'h60,8'h00,8'hFF,8'h05, 8'h00,8'h05,1,0,0);
    tv[1]  = v(0,0,1,0,8'h60,8'h00,8'hFF,8'h05, 8'h60,8'h65,1,0,0);
    tv[2]  = v(0,0,1,0,8'h60,8'h00,8'hFF,8'h05, 8'hC0,8'hC5,1,0,0);
    tv[3]  = v(0,0,1,0,8'h60,8'h00,8'hFF,8'h05, 8'h20,8'h25,1,0,0);
    tv[4]  = v(0,0,1,0,8'h60,8'h00,8'hFF,8'h05, 8'h80,8'h85,1,0,0);
    tv[5]  = v(0,0,0,0,8'h60,8'h00,8'hFF,8'h05, 8'h80,8'h85,1,0,0);
    tv[6]  = v(0,1,1,0,8'h60,8'h00,8'hFF,8'h05, 8'h80,8'h85,0,0,0);
    // BOUNDED 0x10..0x30, ch1 offset 0xF8; row 12 changes live config
    tv[7]  = v(1,0,0,1,8'h10,8'h10,8'h30,8'hF8, 8'h10,8'h08,1,0,0);
    tv[8]  = v(0,0,1,1,8'h10,8'h10,8'h30,8'hF8, 8'h20,8'h18,1,0,0);
    tv[9]  = v(0,0,1,1,8'h10,8'h10,8'h30,8'hF8, 8'h30,8'h28,1,0,0);
    tv[10] = v(0,0,1,1,8'h10,8'h10,8'h30,8'hF8, 8'h10,8'h08,1,0,0);
    tv[11] = v(0,0,1,1,8'h10,8'h10,8'h30,8'hF8, 8'h20,8'h18,1,0,0);
    tv[12] = v(0,0,1,0,8'h50,8'h00,8'hFF,8'hF8, 8'h30,8'h28,1,0,0);
    tv[13] = v(0,1,0,0,8'h50,8'h00,8'hFF,8'hF8, 8'h30,8'h28,0,0,0);
    // ONESHOT 0..0x25 by 0x10, then restart from DONE
    tv[14] = v(1,0,0,2,8'h10,8'h00,8'h25,8'h00, 8'h00,8'h00,1,0,0);
    tv[15] = v(0,0,1,2,8'h10,8'h00,8'h25,8'h00, 8'h10,8'h10,1,0,0);
    tv[16] = v(0,0,1,2,8'h10,8'h00,8'h25,8'h00, 8'h20,8'h20,1,0,0);
    tv[17] = v(0,0,1,2,8'h10,8'h00,8'h25,8'h00, 8'h25,8'h25,0,1,0);
    tv[18] = v(0,0,0,2,8'h10,8'h00,8'h25,8'h00, 8'h25,8'h25,0,1,0);
    tv[19] = v(1,0,0,2,8'h10,8'h00,8'h25,8'h00, 8'h00,8'h00,1,0,0);
    tv[20] = v(0,1,0,2,8'h10,8'h00,8'h25,8'h00, 8'h00,8'h00,0,0,0);
    // Bad window sets cfg_err; good start clears it; stop beats start
    tv[21] = v(1,0,0,0,8'h01,8'h40,8'h20,8'h00, 8'h00,8'h00,0,0,1);
    tv[22] = v(0,0,1,0,8'h01,8'h40,8'h20,8'h00, 8'h00,8'h00,0,0,1);
    tv[23] = v(1,0,0,0,8'h01,8'h20,8'h40,8'h00, 8'h20,8'h20,1,0,0);
    tv[24] = v(1,1,1,0,8'h01,8'h20,8'h40,8'h00, 8'h20,8'h20,0,0,0);
    // ONESHOT with incr=0 never moves
    tv[25] = v(1,0,0,2,8'h00,8'h00,8'h10,8'h00, 8'h00,8'h00,1,0,0);
    tv[26] = v(0,0,1,2,8'h00,8'h00,8'h10,8'h00, 8'h00,8'h00,1,0,0);
    tv[27] = v(0,0,1,2,8'h00,8'h00,8'h10,8'h00, 8'h00,8'h00,1,0,0);
    tv[28] = v(0,1,0,2,8'h00,8'h00,8'h10,8'h00, 8'h00,8'h00,0,0,0);
    // start while running is ignored, even with a bad window
    tv[29] = v(1,0,0,1,8'h10,8'h10,8'h30,8'h00, 8'h10,8'h10,1,0,0);
    tv[30] = v(1,0,1,1,8'h10,8'h50,8'h60,8'h00, 8'h20,8'h20,1,0,0);
    tv[31] = v(1,0,0,1,8'h10,8'h60,8'h50,8'h00, 8'h20,8'h20,1,0,0);
    tv[32] = v(0,1,0,1,8'h10,8'h60,8'h50,8'h00, 8'h20,8'h20,0,0,0);
    // mode 11 behaves as WRAP, ignoring hi
    tv[33] = v(1,0,0,3,8'h20,8'hF0,8'hFF,8'h01, 8'hF0,8'hF1,1,0,0);
    tv[34] = v(0,0,1,3,8'h20,8'hF0,8'hFF,8'h01, 8'h10,8'h11,1,0,0);
    tv[35] = v(0,1,0,3,8'h20,8'hF0,8'hFF,8'h01, 8'h10,8'h11,0,0,0);
    // BOUNDED sum past 2^WIDTH must reload, not wrap
    tv[36] = v(1,0,0,1,8'h20,8'hF0,8'hFF,8'h00, 8'hF0,8'hF0,1,0,0);
    tv[37] = v(0,0,1,1,8'h20,8'hF0,8'hFF,8'h00, 8'hF0,8'hF0,1,0,0);
    tv[38] = v(0,1,0,1,8'h20,8'hF0,8'hFF,8'h00, 8'hF0,8'hF0,0,0,0);

    rst = 1'b1;
    start = 1'b0; stop = 1'b0; en = 1'b0;
    mode = 2'b00; incr = 8'h00; lo = 8'h00; hi = 8'h00;
    offset = {8'h34, 8'h12};
`ifdef ADDR_GEN_DIR_EN
    dir = 1'b0;
`endif
    #2;
    chk("rst addr0", addr[7:0], 8'h12);
    chk("rst addr1", addr[15:8], 8'h34);
    chk("rst busy", {7'd0, busy}, 8'h00);
    chk("rst done", {7'd0, done}, 8'h00);
    chk("rst err", {7'd0, cfg_err}, 8'h00);
    #2 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start = tv[i].st; stop = tv[i].sp; en = tv[i].en;
      mode = tv[i].mode; incr = tv[i].incr;
      lo = tv[i].lo; hi = tv[i].hi;
      offset = {tv[i].off1, 8'h00};
      tick();
      chk($sformatf("v%0d acc", i), addr[7:0], tv[i].e_acc);
      chk($sformatf("v%0d addr1", i), addr[15:8], tv[i].e_a1);
      chk($sformatf("v%0d busy", i), {7'd0, busy}, {7'd0, tv[i].e_busy});
      chk($sformatf("v%0d done", i), {7'd0, done}, {7'd0, tv[i].e_done});
      chk($sformatf("v%0d err", i), {7'd0, cfg_err}, {7'd0, tv[i].e_err});
    end
    start = 1'b0; stop = 1'b0; en = 1'b0;

    // Live offset change is visible without a clock edge
    offset = {8'h02, 8'h01};
    #1;
    chk("live off0", addr[7:0], 8'hF1);
    chk("live off1", addr[15:8], 8'hF2);

    // Asynchronous reset mid-RUN at acc=0x80
    offset = {8'h00, 8'h03};
    mode = 2'b00; incr = 8'h80; lo = 8'h00; hi = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    tick();
    chk("mid acc", addr[7:0], 8'h83);
    chk("mid busy", {7'd0, busy}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst acc", addr[7:0], 8'h03);
    chk("arst busy", {7'd0, busy}, 8'h00);
    chk("arst done", {7'd0, done}, 8'h00);
    #1 rst = 1'b0;
    en = 1'b0;

    // Reset clears sticky cfg_err and DONE
    lo = 8'h40; hi = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre err", {7'd0, cfg_err}, 8'h01);
    mode = 2'b10; incr = 8'h10; lo = 8'h00; hi = 8'h05; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    chk("pre done", {7'd0, done}, 8'h01);
    chk("pre acc", addr[7:0], 8'h08);
    chk("pre err2", {7'd0, cfg_err}, 8'h00);
    lo = 8'h40; hi = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done err", {7'd0, cfg_err}, 8'h01);
    chk("done hold", {7'd0, done}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst2 done", {7'd0, done}, 8'h00);
    chk("arst2 err", {7'd0, cfg_err}, 8'h00);
    chk("arst2 acc", addr[7:0], 8'h03);
    #1 rst = 1'b0;

`ifdef ADDR_GEN_DIR_EN
    begin
      logic [7:0] exp_dn [4];
      exp_dn[0] = 8'h30; exp_dn[1] = 8'h20;
      exp_dn[2] = 8'h10; exp_dn[3] = 8'h30;
      offset = 16'h0000;
      dir = 1'b1; mode = 2'b01; incr = 8'h10; lo = 8'h10; hi = 8'h30;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("dn 0", addr[7:0], exp_dn[0]);
      en = 1'b1;
      for (int j = 1; j < 4; j++) begin
        tick();
        chk($sformatf("dn %0d", j), addr[7:0], exp_dn[j]);
      end
      en = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
      mode = 2'b10; incr = 8'h20; lo = 8'h08; hi = 8'h30;
      start = 1'b1;
      tick();
      start = 1'b0; en = 1'b1;
      tick();
      chk("dn os 1", addr[7:0], 8'h10);
      tick();
      chk("dn os 2", addr[7:0], 8'h08);
      chk("dn os done", {7'd0, done}, 8'h01);
      en = 1'b0; dir = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_gen.md
ADDR_GEN -- requirements
Module: addr_gen

Interface
REQ-001 Parameter: WIDTH, 8, accumulator/address width in bits.
REQ-002 Parameter: NCH, 2, number of address output channels (1..8).
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to begin a run.
REQ-006 Port: stop  input  1  one-cycle request to abort a run.
REQ-007 Port: en  input  1  step enable; accumulator holds while low.
REQ-008 Port: mode  input  2  00 WRAP, 01 BOUNDED, 10 ONESHOT, 11 reserved (treated as WRAP).
REQ-009 Port: incr  input  WIDTH  step size per enabled cycle.
REQ-010 Port: lo, hi  input  WIDTH each  inclusive address window.
REQ-011 Port: offset  input  NCH*WIDTH  per-channel phase offset, channel k at bits [k*WIDTH +: WIDTH].
REQ-012 Port: addr  output  NCH*WIDTH  per-channel address, same packing as offset.
REQ-013 Port: busy  output  1  high while in RUN.
REQ-014 Port: done  output  1  high while in DONE.
REQ-015 Port: cfg_err  output  1  sticky configuration error flag.

Function
REQ-016 FSM states IDLE, RUN, DONE; busy/done decoded from the state register.
REQ-017 IDLE/DONE + start, lo<=hi: acc <= lo, latch mode/lo/hi/incr, go RUN next cycle.
REQ-018 IDLE/DONE + start, lo>hi: stay put, set cfg_err, acc unchanged.
REQ-019 RUN + stop: go IDLE, acc holds; stop beats simultaneous start; start in RUN ignored.
REQ-020 RUN, en=1, WRAP: acc <= (acc + incr) mod 2^WIDTH.
REQ-021 RUN, en=1, BOUNDED: sum = acc + incr at WIDTH+1 bits; sum > hi -> acc <= lo, else acc <= sum.
REQ-022 RUN, en=1, ONESHOT: sum > hi -> acc <= hi and go DONE; else acc <= sum.
REQ-023 RUN, en=0, or incr=0: acc holds, state unchanged (ONESHOT with incr=0 never completes).
REQ-024 addr[k] = (acc + offset[k]) mod 2^WIDTH, combinational from acc and live offset; visible same cycle acc updates.
REQ-025 Mid-run changes to mode/lo/hi/incr ignored until next accepted start; offset is live.
REQ-026 cfg_err cleared only by reset or by an accepted start with lo<=hi.

Reset
REQ-027 Asserting rst at any time, including mid-run: state IDLE, acc 0, cfg_err 0, all latched config 0, within the same cycle.
REQ-028 After reset: busy=0, done=0, cfg_err=0, addr[k]=offset[k].

Configuration
REQ-029 Macro ADDR_GEN_DIR_EN defined: extra port dir (input, 1, 0=up 1=down), latched at start.
REQ-030 With dir=1: start loads acc <= hi; WRAP subtracts incr mod 2^WIDTH; BOUNDED acc - incr < lo -> acc <= hi; ONESHOT acc - incr < lo -> acc <= lo, go DONE.
REQ-031 Macro undefined: no dir port, counting always up, behaviour per REQ-017..REQ-025.

Verification
REQ-032 WIDTH=8, WRAP, incr=0x60, start from lo=0 -> acc 00,60,C0,20,80; busy=1 throughout.
REQ-033 BOUNDED, lo=0x10, hi=0x30, incr=0x10 -> acc 10,20,30,10,20; offset ch1=0xF8 -> addr1 08,18,28,08.
REQ-034 ONESHOT, lo=0, hi=0x25, incr=0x10 -> acc 00,10,20,25, done=1, busy=0; next start -> acc 00, RUN.
REQ-035 start with lo=0x40, hi=0x20 -> state IDLE, cfg_err=1; later valid start -> cfg_err=0, RUN.
REQ-036 rst pulsed mid-RUN at acc=0x80 -> acc 0, IDLE, done 0 same cycle; start+stop same cycle in RUN -> IDLE.
REQ-037 ADDR_GEN_DIR_EN, dir=1, BOUNDED lo=0x10, hi=0x30, incr=0x10 -> acc 30,20,10,30.
